// File: rtl/imem_fetch_arbiter.sv
// Arbitrates the single-port instruction BRAM between fetch and debug readers.
// It tracks the owner of each in-flight read and routes the returned data back to that owner.
module imem_fetch_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int DBG_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              f_flush,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WAIT_W = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DBG_MAX_WAIT);

    logic [WAIT_W-1:0] d_wait;
    logic              starved;
    logic [RD_LAT-1:0] pipe_valid;
    logic [RD_LAT-1:0] pipe_dbg;
    logic [RD_LAT-1:0] pipe_live;

    // With DBG_MAX_WAIT of zero the counter never leaves zero, so debug always wins.
    always_comb begin
        starved = d_req && (d_wait == WAIT_MAX);
        f_gnt   = 1'b0;
        d_gnt   = 1'b0;
        if (!rst) begin
            if (starved)    d_gnt = 1'b1;
            else if (f_req) f_gnt = 1'b1;
            else if (d_req) d_gnt = 1'b1;
        end
        mem_en   = f_gnt | d_gnt;
        mem_addr = d_gnt ? d_addr : f_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_wait <= '0;
        end else if (d_req && !d_gnt) begin
            if (d_wait != WAIT_MAX) d_wait <= d_wait + 1'b1;
        end else begin
            d_wait <= '0;
        end
    end

    // A flush kills older fetch entries. This includes the one returning in the same cycle.
    always_comb begin
        pipe_live = pipe_valid & ~(f_flush ? ~pipe_dbg : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_dbg   <= '0;
        end else begin
            pipe_valid[0] <= mem_en;
            pipe_dbg[0]   <= d_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_live[i-1];
                pipe_dbg[i]   <= pipe_dbg[i-1];
            end
        end
    end

    always_comb begin
        f_rvalid = pipe_live[RD_LAT-1] && !pipe_dbg[RD_LAT-1];
        d_rvalid = pipe_valid[RD_LAT-1] && pipe_dbg[RD_LAT-1];
        f_rdata  = mem_rdata;
        d_rdata  = mem_rdata;
    end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Randomised scoreboard bench for imem_fetch_arbiter against a queue-based reference model.
// The stimulus pushes expected grants and returns into queues, and a negedge monitor pops them and compares.
module tb_imem_fetch_arbiter;

    localparam int ADDR_W       = 8;
    localparam int DATA_W       = 32;
    localparam int RD_LAT       = 2;
    localparam int DBG_MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              f_req = 1'b0, d_req = 1'b0, f_flush = 1'b0;
    logic [ADDR_W-1:0] f_addr = '0, d_addr = '0;
    logic              f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en;
    logic [DATA_W-1:0] f_rdata, d_rdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    always #5 clk = ~clk;

    imem_fetch_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .DBG_MAX_WAIT(DBG_MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    // Behavioural BRAM with RD_LAT output stages
    logic [DATA_W-1:0] word [256];
    logic [DATA_W-1:0] bram_pipe [RD_LAT];
    always @(posedge clk) begin
        bram_pipe[0] <= mem_en ? word[mem_addr] : '0;
        for (int i = 1; i < RD_LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign mem_rdata = bram_pipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit                fg;
        bit                dg;
        logic [ADDR_W-1:0] addr;
    } grant_t;
    typedef struct {
        int                due;
        bit                dbg;
        logic [DATA_W-1:0] data;
    } ret_t;

    grant_t gq[$];
    ret_t   rq[$];
    int     m_wait = 0;
    bit     exp_fg, exp_dg;
    int     checks = 0, passes = 0, fails = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else begin
            fails++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    // One cycle of stimulus plus the reference model's view of that cycle
    task automatic applyStimulus(input bit fr, input logic [ADDR_W-1:0] fa, input bit dr,
                                 input logic [ADDR_W-1:0] da, input bit fl, input bit rs);
        ret_t keep[$];
        @(posedge clk);
        #1;
        f_req = fr; f_addr = fa; d_req = dr; d_addr = da; f_flush = fl; rst = rs;
        exp_fg = 0;
        exp_dg = 0;
        if (rs) begin
            rq.delete();
            m_wait = 0;
        end else begin
            if (dr && m_wait == DBG_MAX_WAIT) exp_dg = 1;
            else if (fr)                      exp_fg = 1;
            else if (dr)                      exp_dg = 1;
            if (fl) begin
                foreach (rq[i]) if (rq[i].dbg) keep.push_back(rq[i]);
                rq = keep;
            end
            if (exp_fg || exp_dg)
                rq.push_back('{due: cyc + RD_LAT, dbg: exp_dg, data: word[exp_dg ? da : fa]});
            if (dr && !exp_dg) m_wait = (m_wait < DBG_MAX_WAIT) ? m_wait + 1 : DBG_MAX_WAIT;
            else               m_wait = 0;
        end
        gq.push_back('{fg: exp_fg, dg: exp_dg, addr: exp_dg ? da : fa});
    endtask

    always @(negedge clk) begin
        grant_t g;
        ret_t   r;
        bit     ef, ed;
        logic [DATA_W-1:0] edata;
        if (gq.size() > 0) begin
            g = gq.pop_front();
            checkOutput("grant{f,d,en}", 64'({f_gnt, d_gnt, mem_en}), 64'({g.fg, g.dg, g.fg | g.dg}));
            if (g.fg || g.dg) checkOutput("mem_addr", 64'(mem_addr), 64'(g.addr));
            ef = 0; ed = 0; edata = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                ef = !r.dbg;
                ed = r.dbg;
                edata = r.data;
            end
            checkOutput("rvalid{f,d}", 64'({f_rvalid, d_rvalid}), 64'({ef, ed}));
            if (ef) checkOutput("f_rdata", 64'(f_rdata), 64'(edata));
            if (ed) checkOutput("d_rdata", 64'(d_rdata), 64'(edata));
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, '0, 0, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] fa, da;
        bit fpend, dpend, fl, rs;
        for (int i = 0; i < 256; i++) word[i] = $urandom;
        for (int i = 0; i < 8; i++) word[i] = 32'(i + 100);

        // Requests during reset are ignored; the grant comes in the cycle reset drops
        applyStimulus(1, 8'd10, 0, '0, 0, 1);
        applyStimulus(1, 8'd10, 1, 8'd11, 0, 1);
        applyStimulus(1, 8'd10, 0, '0, 0, 0);
        idle(3);

        for (int i = 0; i < 8; i++) applyStimulus(1, 8'(i), 0, '0, 0, 0);
        idle(3);

        // Contention: fetch held, debug at addr 5 must win on the fifth cycle
        fa = 8'd40;
        dpend = 1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, fa, dpend, 8'd5, 0, 0);
            if (exp_fg) fa++;
            if (exp_dg) dpend = 0;
        end
        idle(3);

        applyStimulus(1, 8'd3, 0, '0, 0, 0);
        applyStimulus(1, 8'd4, 0, '0, 0, 0);
        applyStimulus(1, 8'd9, 0, '0, 1, 0);
        idle(3);

        applyStimulus(0, '0, 1, 8'd20, 0, 0);
        applyStimulus(1, 8'd21, 0, '0, 0, 0);
        applyStimulus(0, '0, 1, 8'd22, 0, 0);
        applyStimulus(1, 8'd23, 0, '0, 0, 0);
        idle(3);

        applyStimulus(1, 8'd2, 0, '0, 0, 0);
        applyStimulus(0, '0, 0, '0, 0, 1);
        idle(4);

        fpend = 0; dpend = 0; fa = '0; da = '0;
        for (int i = 0; i < 600; i++) begin
            if (!fpend && $urandom_range(0, 3) != 0) begin fpend = 1; fa = 8'($urandom); end
            if (!dpend && $urandom_range(0, 4) == 0) begin dpend = 1; da = 8'($urandom); end
            fl = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 79) == 0);
            applyStimulus(fpend, fa, dpend, da, fl, rs);
            if (exp_fg) fpend = 0;
            if (exp_dg) dpend = 0;
        end
        idle(RD_LAT + 3);
        @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 64'(rq.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
